ring_control_sequencer: RTL and testbench
=========================================

// Module: ring_control_sequencer
// PURPOSE
//  Upstream control unit for the 8-bit bus datapath: six-state one-hot ring counter (T1..T6)
//  plus opcode decode, driving every load/enable strobe of PC, MAR, ROM, IR, ACC, B, ALU, OUT.
//  Consumes op_code (IR[7:4]); its low_halt gates the datapath clock.
// PARAMETERS
//  LDA_OP  4'h0  load ACC from memory[IR[3:0]]
//  ADD_OP  4'h1  ACC <= ACC + memory[IR[3:0]]
//  SUB_OP  4'h2  ACC <= ACC - memory[IR[3:0]]
//  OUT_OP  4'hE  OUT register <= ACC
//  HLT_OP  4'hF  stop clock until clr
// PORTS
//  clk            in   1  rising-edge clock (gated by low_halt upstream)
//  clr            in   1  synchronous active-high reset
//  op_code        in   4  IR[7:4]; valid from T4 onward
//  inc            out  1  PC increment
//  pc_out_en      out  1  PC drives bus[3:0]
//  low_ld_mar     out  1  MAR load, active-low
//  low_mem_out_en out  1  ROM drives bus, active-low
//  low_ld_ir      out  1  IR load, active-low
//  low_ir_out_en  out  1  IR[3:0] drives bus, active-low
//  low_ld_acc     out  1  ACC load, active-low
//  acc_out_en     out  1  ACC drives bus
//  sub_add        out  1  1=subtract, 0=add
//  subadd_out_en  out  1  ALU drives bus
//  low_ld_b_reg   out  1  B load, active-low
//  low_ld_out_reg out  1  OUT load, active-low
//  low_halt       out  1  0 = clock stopped
//  t_state        out  6  one-hot ring state, bit0=T1 (debug)
// BEHAVIOUR
//  - Outputs: pure decode of registered t_state/op_code/halt latch; strobes act at the edge ending a state.
//  - Inactive values: active-high strobes 0, active-low strobes 1, sub_add 0.
//  - clr (sync): t_state<=T1, halt latch<=0. Post-reset outputs = T1 decode: pc_out_en=1,
//    low_ld_mar=0, low_halt=1, all others inactive.
//  - low_halt = ~halt_q | clr (combinational) so gated clock restarts and clr lands on next edge.
//  - Ring: T1->T2->..->T6->T1 each edge; clr overrides any state, including mid-instruction.
//  - Fetch (all ops, op_code ignored): T1 pc_out_en,low_ld_mar=0; T2 inc=1;
//    T3 low_mem_out_en=0,low_ld_ir=0.
//  - LDA: T4 low_ir_out_en=0,low_ld_mar=0; T5 low_mem_out_en=0,low_ld_acc=0; T6 idle.
//  - ADD: T4 as LDA; T5 low_mem_out_en=0,low_ld_b_reg=0; T6 subadd_out_en=1,low_ld_acc=0,sub_add=0.
//  - SUB: as ADD but sub_add=1 in T5 and T6.
//  - OUT: T4 acc_out_en=1,low_ld_out_reg=0; T5,T6 idle.
//  - HLT: T4 sets halt_q at end of T4; low_halt=0 thereafter; ring freezes (clock gated) until clr.
//  - Undefined opcodes: T4..T6 idle (NOP). Never >1 bus driver in any state.
// CONFIGURATION
//  SEQ_EARLY_END_EN defined: ring returns to T1 after last active state: LDA after T5,
//    OUT after T4, undefined after T3; ADD/SUB full 6 states. Not defined: all ops 6 states.
// STRUCTURE
//  Package seq_pkg: opcode localparams, T1..T6 one-hot constants, control-word bit indices.
//  Sub-module ring_counter_6 (one-hot ring, sync clr, early-return input); decode in top of block.
// TESTING
//  1. clr=1 one edge -> t_state=6'b000001, pc_out_en=1, low_ld_mar=0, low_halt=1.
//  2. op_code=4'h0 over 6 clocks -> T4 low_ir_out_en=0&low_ld_mar=0; T5 low_ld_acc=0; T6 idle.
//  3. op_code=4'h2 -> T5 low_ld_b_reg=0; T6 subadd_out_en=1, sub_add=1, low_ld_acc=0; 4'h1 gives sub_add=0.
//  4. op_code=4'hF -> low_halt=0 after T4 edge; clr=1 -> low_halt=1 same cycle, T1 next edge.
//  5. clr asserted in T5 of ADD -> next state T1, no low_ld_acc pulse.
//  6. SEQ_EARLY_END_EN: op_code=4'hE -> T4 then T1 (4-cycle instr); 4'h7 -> 3-cycle; without macro both 6.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Opcodes, one-hot ring states and control-word bit indices shared
//            by the ring control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [3:0] LDA_OP = 4'h0;
    localparam logic [3:0] ADD_OP = 4'h1;
    localparam logic [3:0] SUB_OP = 4'h2;
    localparam logic [3:0] OUT_OP = 4'hE;
    localparam logic [3:0] HLT_OP = 4'hF;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_state_e;

    // Control word holds every strobe in its asserted (active-high) sense.
    localparam int CW_INC      = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_LD_MAR   = 2;
    localparam int CW_MEM_OUT  = 3;
    localparam int CW_LD_IR    = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_LD_ACC   = 6;
    localparam int CW_ACC_OUT  = 7;
    localparam int CW_SUB_ADD  = 8;
    localparam int CW_ALU_OUT  = 9;
    localparam int CW_LD_B     = 10;
    localparam int CW_LD_OUT   = 11;
    localparam int CW_W        = 12;

    function automatic logic is_defined_op(input logic [3:0] op);
        return (op == LDA_OP) || (op == ADD_OP) || (op == SUB_OP) ||
               (op == OUT_OP) || (op == HLT_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_counter_6.sv
`default_nettype none
// ============================================================================
// Module   : ring_counter_6
// Brief    : Six-state one-hot ring T1..T6 with sync clear, hold and an
//            early-return request that sends the ring back to T1.
// Revision : 1.0 - initial release
// ============================================================================
module ring_counter_6
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        hold,
    input  logic        early_end,
    output ring_state_e state
);

    ring_state_e next_state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= T1;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = T1;
        if (hold) begin
            next_state = state;
        end else if (early_end) begin
            next_state = T1;
        end else begin
            case (state)
                T1:      next_state = T2;
                T2:      next_state = T3;
                T3:      next_state = T4;
                T4:      next_state = T5;
                T5:      next_state = T6;
                T6:      next_state = T1;
                default: next_state = T1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ring_control_sequencer
// Brief    : Ring-counter control unit decoding T-state and opcode into the
//            datapath strobes. Define SEQ_EARLY_END_EN to end short
//            instructions early.
// Revision : 1.0 - initial release
// ============================================================================
module ring_control_sequencer
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] op_code,
    output logic       inc,
    output logic       pc_out_en,
    output logic       low_ld_mar,
    output logic       low_mem_out_en,
    output logic       low_ld_ir,
    output logic       low_ir_out_en,
    output logic       low_ld_acc,
    output logic       acc_out_en,
    output logic       sub_add,
    output logic       subadd_out_en,
    output logic       low_ld_b_reg,
    output logic       low_ld_out_reg,
    output logic       low_halt,
    output logic [5:0] t_state
);

    ring_state_e        state;
    logic               halt_q;
    logic               early_end;
    logic [CW_W-1:0]    cw;

`ifdef SEQ_EARLY_END_EN
    assign early_end = ((state == T5) && (op_code == LDA_OP)) ||
                       ((state == T4) && (op_code == OUT_OP)) ||
                       ((state == T3) && !is_defined_op(op_code));
`else
    assign early_end = 1'b0;
`endif

    ring_counter_6 u_ring (
        .clk       (clk),
        .clr       (clr),
        .hold      (halt_q),
        .early_end (early_end),
        .state     (state)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            halt_q <= 1'b0;
        end else if ((state == T4) && (op_code == HLT_OP)) begin
            halt_q <= 1'b1;
        end
    end

    always_comb begin
        cw = '0;
        case (state)
            T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_LD_MAR] = 1'b1;
            end
            T2: cw[CW_INC] = 1'b1;
            T3: begin
                cw[CW_MEM_OUT] = 1'b1;
                cw[CW_LD_IR]   = 1'b1;
            end
            T4: begin
                case (op_code)
                    LDA_OP, ADD_OP, SUB_OP: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_LD_MAR] = 1'b1;
                    end
                    OUT_OP: begin
                        cw[CW_ACC_OUT] = 1'b1;
                        cw[CW_LD_OUT]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op_code)
                    LDA_OP: begin
                        cw[CW_MEM_OUT] = 1'b1;
                        cw[CW_LD_ACC]  = 1'b1;
                    end
                    ADD_OP, SUB_OP: begin
                        cw[CW_MEM_OUT] = 1'b1;
                        cw[CW_LD_B]    = 1'b1;
                        cw[CW_SUB_ADD] = (op_code == SUB_OP);
                    end
                    default: ;
                endcase
            end
            T6: begin
                if ((op_code == ADD_OP) || (op_code == SUB_OP)) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_LD_ACC]  = 1'b1;
                    cw[CW_SUB_ADD] = (op_code == SUB_OP);
                end
            end
            default: ;
        endcase
    end

    assign inc            =  cw[CW_INC];
    assign pc_out_en      =  cw[CW_PC_OUT];
    assign low_ld_mar     = ~cw[CW_LD_MAR];
    assign low_mem_out_en = ~cw[CW_MEM_OUT];
    assign low_ld_ir      = ~cw[CW_LD_IR];
    assign low_ir_out_en  = ~cw[CW_IR_OUT];
    assign low_ld_acc     = ~cw[CW_LD_ACC];
    assign acc_out_en     =  cw[CW_ACC_OUT];
    assign sub_add        =  cw[CW_SUB_ADD];
    assign subadd_out_en  =  cw[CW_ALU_OUT];
    assign low_ld_b_reg   = ~cw[CW_LD_B];
    assign low_ld_out_reg = ~cw[CW_LD_OUT];
    // clr reopens the gated clock so the synchronous clear can land.
    assign low_halt       = ~halt_q | clr;
    assign t_state        = state;

endmodule
`default_nettype wire

// File: tb/tb_ring_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_control_sequencer
// Brief    : Randomized scoreboard bench for ring_control_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_control_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] op_code;
    logic       inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir;
    logic       low_ir_out_en, low_ld_acc, acc_out_en, sub_add, subadd_out_en;
    logic       low_ld_b_reg, low_ld_out_reg, low_halt;
    logic [5:0] t_state;

    typedef logic [18:0] pins_t;

    pins_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step   = 1;
    bit    halted = 1'b0;

    always #5 clk = ~clk;

    ring_control_sequencer dut (
        .clk            (clk),
        .clr            (clr),
        .op_code        (op_code),
        .inc            (inc),
        .pc_out_en      (pc_out_en),
        .low_ld_mar     (low_ld_mar),
        .low_mem_out_en (low_mem_out_en),
        .low_ld_ir      (low_ld_ir),
        .low_ir_out_en  (low_ir_out_en),
        .low_ld_acc     (low_ld_acc),
        .acc_out_en     (acc_out_en),
        .sub_add        (sub_add),
        .subadd_out_en  (subadd_out_en),
        .low_ld_b_reg   (low_ld_b_reg),
        .low_ld_out_reg (low_ld_out_reg),
        .low_halt       (low_halt),
        .t_state        (t_state)
    );

    function automatic bit is_def(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) ||
               (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        if (op == 4'h0) return 5;
        if (op == 4'hE) return 4;
        if (!is_def(op)) return 3;
`endif
        return 6;
    endfunction

    // Expected pin levels for one cycle: step number 1..6, opcode, halt, clr.
    function automatic pins_t model(input int s, input logic [3:0] op,
                                    input bit h, input bit c);
        bit i_inc = 0, pc = 0, mar = 0, mem = 0, ir = 0, irout = 0, acc = 0;
        bit accout = 0, sa = 0, alu = 0, bl = 0, outr = 0;
        bit arith = (op == 4'h1) || (op == 4'h2);
        logic [5:0] ts = 6'(1 << (s - 1));
        case (s)
            1: begin pc = 1; mar = 1; end
            2: i_inc = 1;
            3: begin mem = 1; ir = 1; end
            4: begin
                if (op == 4'h0 || arith) begin irout = 1; mar = 1; end
                if (op == 4'hE) begin accout = 1; outr = 1; end
            end
            5: begin
                if (op == 4'h0) begin mem = 1; acc = 1; end
                if (arith) begin mem = 1; bl = 1; sa = (op == 4'h2); end
            end
            6: if (arith) begin alu = 1; acc = 1; sa = (op == 4'h2); end
            default: ;
        endcase
        return {ts, i_inc, pc, ~mar, ~mem, ~ir, ~irout, ~acc, accout,
                sa, alu, ~bl, ~outr, (~h) | c};
    endfunction

    task automatic drive(input bit c, input logic [3:0] op);
        @(posedge clk);
        #1;
        clr     = c;
        op_code = op;
        exp_q.push_back(model(step, op, halted, c));
        if (c) begin
            step   = 1;
            halted = 1'b0;
        end else if (!halted) begin
            if (step == 4 && op == 4'hF) halted = 1'b1;
            step = (step >= instr_len(op)) ? 1 : step + 1;
        end
    endtask

    // One instruction from T1; clr_at (1..6) asserts clr during that step.
    task automatic run_instr(input logic [3:0] op, input int clr_at);
        int n = 0;
        bit c;
        do begin
            c = (step == clr_at);
            drive(c, op);
            n++;
        end while (step != 1 && !halted && n < 20);
        if (halted) begin
            repeat ($urandom_range(1, 4)) drive(1'b0, op);
            drive(1'b1, op);
        end
    endtask

    always @(negedge clk) begin
        pins_t got, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {t_state, inc, pc_out_en, low_ld_mar, low_mem_out_en,
                   low_ld_ir, low_ir_out_en, low_ld_acc, acc_out_en, sub_add,
                   subadd_out_en, low_ld_b_reg, low_ld_out_reg, low_halt};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t op=%h clr=%b: got %b expected %b (t_state..low_halt)",
                         $time, op_code, clr, got, e);
            end
        end
    end

    initial begin
        logic [3:0] defined_ops [5];
        logic [3:0] op;
        int         ca;
        defined_ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
        clr     = 1'b1;
        op_code = 4'h0;
        repeat (2) @(posedge clk);
        drive(1'b1, 4'h0);

        run_instr(4'h0, 0);
        run_instr(4'h1, 0);
        run_instr(4'h2, 0);
        run_instr(4'hE, 0);
        run_instr(4'h7, 0);
        run_instr(4'h1, 5);
        run_instr(4'hF, 0);
        run_instr(4'h2, 3);
        run_instr(4'h0, 0);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 7) < 5)
                op = defined_ops[$urandom_range(0, 4)];
            else
                op = 4'($urandom_range(3, 13));
            ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_instr(op, ca);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
